// File: rtl/i_mem_responder_if.sv
// Cache-side refill port of the instruction-memory responder.
// master = i-cache miss port, slave = i_mem_responder.
interface i_mem_responder_if #(
  parameter int A_WIDTH = 32
);
  logic [A_WIDTH-1:0] s_a;
  logic               s_strobe;
  logic [31:0]        s_dout;
  logic               s_ready;

  modport master (output s_a, output s_strobe, input s_dout, input s_ready);
  modport slave  (input s_a, input s_strobe, output s_dout, output s_ready);
endinterface

// File: rtl/i_mem_responder.sv
// Instruction-memory responder for the i-cache refill port.
// Accepts a miss request, inserts WAIT_CYCLES wait states, issues one
// synchronous memory read and returns the word with a one-cycle s_ready.
// A request the cache withdraws (strobe drop or address change) is abandoned.
// Optional: define IMEM_RANGE_CHECK_EN to add out-of-range detection and the
// sticky range_err output; without it addresses alias modulo 2^MEM_AW words.
//
// state | meaning
// IDLE  | waiting for s_strobe; latches the request address
// WAIT  | counting down wait states
// READ  | mem_en high for one cycle
// CAPT  | memory data arrives; captured into the response register
// RESP  | s_dout valid; s_ready pulses if the request is still presented
module i_mem_responder #(
  parameter int          A_WIDTH     = 32,
  parameter int          MEM_AW      = 14,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              rst,
  i_mem_responder_if.slave  s,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
`ifdef IMEM_RANGE_CHECK_EN
  ,
  output logic              range_err
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_CAPT,
    ST_RESP
  } state_t;

  localparam logic [A_WIDTH-1:0] BASE_A   = A_WIDTH'(BASE_ADDR);
  localparam logic [7:0]         CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  state_t             state;
  logic [A_WIDTH-1:0] a_q;
  logic [7:0]         cnt;
  logic [31:0]        dout_q;

  logic [A_WIDTH-1:0] diff_in;
  logic [A_WIDTH-1:0] diff_q;
  logic [MEM_AW-1:0]  off_in;
  logic [MEM_AW-1:0]  off_q;
  logic               oor_in;
  logic               oor_q;
  logic               abort;
  logic               unused_bits;

  // Word offsets of the incoming and the latched address relative to BASE_ADDR
  assign diff_in = s.s_a - BASE_A;
  assign diff_q  = a_q - BASE_A;
  assign off_in  = diff_in[MEM_AW+1:2];
  assign off_q   = diff_q[MEM_AW+1:2];

`ifdef IMEM_RANGE_CHECK_EN
  assign oor_in = (s.s_a < BASE_A) || ((diff_in >> (MEM_AW + 2)) != '0);
  assign oor_q  = (a_q < BASE_A) || ((diff_q >> (MEM_AW + 2)) != '0);
`else
  assign oor_in = 1'b0;
  assign oor_q  = 1'b0;
`endif

  // Byte-lane bits and (without range checking) the aliased high bits are dropped
  assign unused_bits = ^{diff_in[1:0], diff_q[1:0],
                         diff_in[A_WIDTH-1:MEM_AW+2], diff_q[A_WIDTH-1:MEM_AW+2]};

  // The cache withdraws a request by dropping strobe or moving to another address
  assign abort = !s.s_strobe || (s.s_a != a_q);

  // Sequencer: request latch, wait-state countdown, single read, capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      cnt      <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      dout_q   <= '0;
`ifdef IMEM_RANGE_CHECK_EN
      range_err <= 1'b0;
`endif
    end else begin
      mem_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s.s_strobe) begin
            a_q <= s.s_a;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state    <= ST_READ;
              mem_en   <= !oor_in;
              mem_addr <= off_in;
            end
          end
        end
        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (cnt == 8'd0) begin
            state    <= ST_READ;
            mem_en   <= !oor_q;
            mem_addr <= off_q;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_READ: begin
          state <= abort ? ST_IDLE : ST_CAPT;
        end
        ST_CAPT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            state  <= ST_RESP;
            // Out-of-range fetches return a NOP instead of memory data
            dout_q <= oor_q ? 32'h0000_0000 : mem_rdata;
`ifdef IMEM_RANGE_CHECK_EN
            if (oor_q) begin
              range_err <= 1'b1;
            end
`endif
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // s_ready is qualified live so a request withdrawn during RESP gets no pulse
  assign s.s_ready = (state == ST_RESP) && s.s_strobe && (s.s_a == a_q);
  assign s.s_dout  = dout_q;

endmodule

// File: tb/tb_i_mem_responder.sv
// Directed bench for i_mem_responder: one instance with WAIT_CYCLES=2 and one
// with WAIT_CYCLES=0, each behind a synchronous-read memory model.
module tb_i_mem_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  i_mem_responder_if #(.A_WIDTH(32)) bus2 ();
  i_mem_responder_if #(.A_WIDTH(32)) bus0 ();

  logic        mem_en2, mem_en0;
  logic [13:0] mem_addr2, mem_addr0;
  logic [31:0] rdata2, rdata0;
`ifdef IMEM_RANGE_CHECK_EN
  logic        rerr2, rerr0;
`endif

  logic [31:0] mem [0:16383];

  i_mem_responder #(.A_WIDTH(32), .MEM_AW(14), .WAIT_CYCLES(2), .BASE_ADDR(32'hBFC0_0000)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .s         (bus2),
    .mem_en    (mem_en2),
    .mem_addr  (mem_addr2),
    .mem_rdata (rdata2)
`ifdef IMEM_RANGE_CHECK_EN
    ,
    .range_err (rerr2)
`endif
  );

  i_mem_responder #(.A_WIDTH(32), .MEM_AW(14), .WAIT_CYCLES(0), .BASE_ADDR(32'hBFC0_0000)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .s         (bus0),
    .mem_en    (mem_en0),
    .mem_addr  (mem_addr0),
    .mem_rdata (rdata0)
`ifdef IMEM_RANGE_CHECK_EN
    ,
    .range_err (rerr0)
`endif
  );

  // Synchronous-read memory: data is valid the cycle after mem_en
  always @(posedge clk) begin
    if (mem_en2) rdata2 <= mem[mem_addr2];
    if (mem_en0) rdata0 <= mem[mem_addr0];
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic        o_rdy;
  logic        o_en;
  logic [31:0] o_dout;
  logic [13:0] o_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle on the WAIT_CYCLES=2 instance; inputs set at cycle start,
  // outputs sampled mid-cycle on the falling edge
  task automatic cyc2(input logic stb, input logic [31:0] a);
    bus2.s_strobe = stb;
    bus2.s_a      = a;
    @(negedge clk);
    o_rdy  = bus2.s_ready;
    o_dout = bus2.s_dout;
    o_en   = mem_en2;
    o_addr = mem_addr2;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc0(input logic stb, input logic [31:0] a);
    bus0.s_strobe = stb;
    bus0.s_a      = a;
    @(negedge clk);
    o_rdy  = bus0.s_ready;
    o_dout = bus0.s_dout;
    o_en   = mem_en0;
    o_addr = mem_addr0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nrdy;
    int nen;
    logic stb;
    logic [31:0] a;

    for (int i = 0; i < 16384; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[0] = 32'h2408_0001;

    rst = 1'b1;
    bus2.s_strobe = 1'b0; bus2.s_a = '0;
    bus0.s_strobe = 1'b0; bus0.s_a = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready2", {31'd0, bus2.s_ready}, 32'd0);
    chk("rst_dout2", bus2.s_dout, 32'd0);
    chk("rst_en2", {31'd0, mem_en2}, 32'd0);
    chk("rst_addr2", {18'd0, mem_addr2}, 32'd0);
    chk("rst_ready0", {31'd0, bus0.s_ready}, 32'd0);
    chk("rst_en0", {31'd0, mem_en0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic read, WAIT_CYCLES=2: READ in cycle 3, s_ready in cycle 5
    nrdy = 0; nen = 0;
    for (int c = 0; c < 8; c++) begin
      cyc2(c <= 5, 32'hBFC0_0000);
      nrdy += int'(o_rdy); nen += int'(o_en);
      if (c == 3) begin
        chk("basic_en", {31'd0, o_en}, 32'd1);
        chk("basic_addr", {18'd0, o_addr}, 32'd0);
      end
      if (c == 4) chk("basic_early", {31'd0, o_rdy}, 32'd0);
      if (c == 5) begin
        chk("basic_ready", {31'd0, o_rdy}, 32'd1);
        chk("basic_dout", o_dout, 32'h2408_0001);
      end
      if (c == 7) chk("basic_hold", o_dout, 32'h2408_0001);
    end
    chk("basic_nrdy", nrdy, 32'd1);
    chk("basic_nen", nen, 32'd1);

    // Zero wait states: READ in cycle 1, s_ready in cycle 3
    nrdy = 0;
    for (int c = 0; c < 6; c++) begin
      cyc0(c <= 3, 32'hBFC0_0010);
      nrdy += int'(o_rdy);
      if (c == 1) begin
        chk("zw_en", {31'd0, o_en}, 32'd1);
        chk("zw_addr", {18'd0, o_addr}, 32'd4);
      end
      if (c == 3) begin
        chk("zw_ready", {31'd0, o_rdy}, 32'd1);
        chk("zw_dout", o_dout, 32'hC0DE_0004);
      end
    end
    chk("zw_nrdy", nrdy, 32'd1);

    // Strobe drop in WAIT, new request at cycle 4 responds at cycle 9
    nrdy = 0; nen = 0;
    for (int c = 0; c < 13; c++) begin
      stb = (c <= 1) || (c >= 4 && c <= 9);
      a   = (c < 4) ? 32'hBFC0_0008 : 32'hBFC0_000C;
      cyc2(stb, a);
      nrdy += int'(o_rdy); nen += int'(o_en);
      if (c == 7) chk("drop_addr", {18'd0, o_addr}, 32'd3);
      if (c == 9) begin
        chk("drop_ready", {31'd0, o_rdy}, 32'd1);
        chk("drop_dout", o_dout, 32'hC0DE_0003);
      end
    end
    chk("drop_nrdy", nrdy, 32'd1);
    chk("drop_nen", nen, 32'd1);

    // Address change in WAIT: first dropped, second (word 16) accepted at cycle 3
    nrdy = 0; nen = 0;
    for (int c = 0; c < 11; c++) begin
      a = (c <= 1) ? 32'hBFC0_0000 : 32'hBFC0_0040;
      cyc2(c <= 8, a);
      nrdy += int'(o_rdy); nen += int'(o_en);
      if (c == 6) chk("achg_addr", {18'd0, o_addr}, 32'd16);
      if (c == 8) begin
        chk("achg_ready", {31'd0, o_rdy}, 32'd1);
        chk("achg_dout", o_dout, 32'hC0DE_0010);
      end
    end
    chk("achg_nrdy", nrdy, 32'd1);
    chk("achg_nen", nen, 32'd1);

    // Request withdrawn in the RESP cycle gets no pulse
    nrdy = 0;
    for (int c = 0; c < 8; c++) begin
      cyc2(c <= 4, 32'hBFC0_0020);
      nrdy += int'(o_rdy);
    end
    chk("resp_wd_nrdy", nrdy, 32'd0);

    // Reset asserted during READ
    nrdy = 0; nen = 0;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) rst = 1'b1;
      if (c == 5) rst = 1'b0;
      cyc2(c <= 3, 32'hBFC0_0004);
      nrdy += int'(o_rdy);
      if (c >= 4) nen += int'(o_en);
      if (c == 3) chk("rstmid_read_en", {31'd0, o_en}, 32'd1);
      if (c == 4) begin
        chk("rstmid_en", {31'd0, o_en}, 32'd0);
        chk("rstmid_ready", {31'd0, o_rdy}, 32'd0);
      end
    end
    chk("rstmid_nrdy", nrdy, 32'd0);
    chk("rstmid_nen", nen, 32'd0);

`ifdef IMEM_RANGE_CHECK_EN
    @(negedge clk);
    chk("rerr_clear", {31'd0, rerr2}, 32'd0);
    @(posedge clk); #1;
    nrdy = 0; nen = 0;
    for (int c = 0; c < 8; c++) begin
      cyc2(c <= 5, 32'h8000_0000);
      nrdy += int'(o_rdy); nen += int'(o_en);
      if (c == 5) begin
        chk("rng_ready", {31'd0, o_rdy}, 32'd1);
        chk("rng_dout", o_dout, 32'h0000_0000);
      end
    end
    chk("rng_nen", nen, 32'd0);
    chk("rng_nrdy", nrdy, 32'd1);
    @(negedge clk);
    chk("rerr_sticky", {31'd0, rerr2}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rerr_rst", {31'd0, rerr2}, 32'd0);
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
